uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
//
// PURPOSE
// Buffered, configurable UART transmitter: next generation of the fixed 8N1 tx.
// Adds a word FIFO with a valid/ready push port, parametrised data width and stop
// bits, and run-time parity selection. Sits between a bus-side producer and the
// serial pin; pairs with the matching uart rx in loopback benches.
//
// PARAMETERS
// cycles_per_bit  4  clocks per serial bit (>=2)
// data_bits       8  payload bits per frame (5..9)
// stop_bits       1  stop bits per frame (1..8)
// fifo_depth      4  FIFO entries (power of 2, >=2)
//
// PORTS
// clk        in   1                  clock
// rst_n      in   1                  reset, asynchronous, active-low
// i_data     in   data_bits          word to transmit
// i_req      in   1                  push request
// i_parity   in   2                  00 none, 01 even, 10 odd, 11 mark (always 1)
// o_cts      out  1                  FIFO can accept (not full)
// o_serial   out  1                  serial line, idle high
// o_idle     out  1                  FIFO empty and FSM in IDLE
// o_count    out  $clog2(fifo_depth+1)  FIFO occupancy
//
// BEHAVIOUR
// - Reset (async): o_serial=1, o_cts=1, o_idle=1, o_count=0; FIFO pointers cleared,
//   FSM->IDLE. Reset mid-frame aborts the frame, drops queued words; no resume.
// - Push: accepted on a posedge where i_req && o_cts. i_req with o_cts=0 ignored,
//   no side effects. o_cts = (count != fifo_depth), combinational from count.
// - Full + pop same cycle: push still refused (o_cts already low); one word/cycle.
// - Pop: at a posedge with FSM in IDLE and count!=0, head word and i_parity latch
//   into the shifter; FSM->START. Push and pop on the same edge: count unchanged.
// - Latency: word accepted at edge E0 into empty FIFO with FSM idle -> popped at
//   E1 -> o_serial low from E1 to E1+cycles_per_bit.
// - FSM: IDLE -> START -> DATA (data_bits bits, LSB first) -> PARITY (skipped if
//   latched mode 00) -> STOP (stop_bits bits, line high) -> IDLE, or STOP -> START
//   directly when count!=0 at the last stop cycle (no idle gap between frames).
// - Bit timing: cycle counter loads cycles_per_bit-1 on bit entry, counts down;
//   bit advances when counter==0. Every bit exactly cycles_per_bit clocks.
// - Parity: even = XOR of data bits; odd = ~XOR; mark = 1. i_parity changes
//   mid-frame have no effect (latched at pop).
// - o_serial registered; driven 1 in IDLE and STOP.
// - o_idle = (count==0) && IDLE; rises the clock after the last stop bit ends.
// - Pointers are $clog2(fifo_depth) bits and wrap naturally; count tracks full.
//
// TESTING (cycles_per_bit=4, data_bits=8, stop_bits=1, fifo_depth=4 unless noted)
// 1 reset, no stimulus -> o_serial=1, o_cts=1, o_idle=1, o_count=0 for 100 clks
// 2 push 0x55, parity 00 -> line 0,1,0,1,0,1,0,1,0,1 each 4 clks (40 clks), then
//   o_idle=1
// 3 push 0x07 even -> parity bit 1; push 0x07 odd -> parity 0; frame 44 clks
// 4 push 6 words on consecutive clks from idle -> 5 accepted, o_cts low after the
//   5th; 5 frames back-to-back, stop bit immediately followed by start bit
// 5 rst_n low during data bit 3 -> o_serial=1 at once, o_count=0; after release
//   line stays high, no partial frame
// 6 data_bits=7, stop_bits=2, parity 11, push 0x00 -> start, 7x0, 1, 1, 1;
//   44 clks total

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: word FIFO with valid/ready push, run-time parity,
// parametrised data width and stop bits. Frames go out back-to-back while words are queued.
module uart_tx_fifo #(
    parameter int cycles_per_bit = 4,
    parameter int data_bits      = 8,
    parameter int stop_bits      = 1,
    parameter int fifo_depth     = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [data_bits-1:0]               i_data,
    input  logic                               i_req,
    input  logic [1:0]                         i_parity,
    output logic                               o_cts,
    output logic                               o_serial,
    output logic                               o_idle,
    output logic [$clog2(fifo_depth+1)-1:0]    o_count
);

    localparam int PTR_W = $clog2(fifo_depth);
    localparam int CNT_W = $clog2(fifo_depth + 1);
    localparam int CYC_W = $clog2(cycles_per_bit);
    localparam int BIT_W = 4;

    localparam logic [CNT_W-1:0] FULL      = CNT_W'(fifo_depth);
    localparam logic [CYC_W-1:0] CYC_LOAD  = CYC_W'(cycles_per_bit - 1);
    localparam logic [BIT_W-1:0] DATA_LOAD = BIT_W'(data_bits - 1);
    localparam logic [BIT_W-1:0] STOP_LOAD = BIT_W'(stop_bits - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    function automatic logic parity_bit(input logic [data_bits-1:0] d, input logic [1:0] mode);
        case (mode)
            2'b01:   return ^d;
            2'b10:   return ~(^d);
            default: return 1'b1;
        endcase
    endfunction

    logic [data_bits-1:0] mem [fifo_depth];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    state_t               state_q, state_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 serial_q, serial_d;

    logic [data_bits-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_q, par_d;

    logic                 push;
    logic                 pop;
    logic                 start_frame;
    logic                 bit_done;
    logic [data_bits-1:0] head;

    assign o_cts    = (count_q != FULL);
    assign o_count  = count_q;
    assign o_serial = serial_q;
    assign o_idle   = (count_q == '0) && (state_q == S_IDLE);

    assign push     = i_req && o_cts;
    assign head     = mem[rd_ptr_q];
    assign bit_done = (cyc_q == '0);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        bit_d       = bit_q;
        serial_d    = serial_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_d       = par_q;
        pop         = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            S_IDLE: begin
                serial_d    = 1'b1;
                start_frame = (count_q != '0);
            end
            S_START: begin
                if (bit_done) begin
                    state_d  = S_DATA;
                    cyc_d    = CYC_LOAD;
                    bit_d    = DATA_LOAD;
                    serial_d = shift_q[0];
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            S_DATA: begin
                if (!bit_done) begin
                    cyc_d = cyc_q - CYC_W'(1);
                end else if (bit_q != '0) begin
                    cyc_d    = CYC_LOAD;
                    bit_d    = bit_q - BIT_W'(1);
                    shift_d  = shift_q >> 1;
                    serial_d = shift_q[1];
                end else if (par_en_q) begin
                    state_d  = S_PARITY;
                    cyc_d    = CYC_LOAD;
                    serial_d = par_q;
                end else begin
                    state_d  = S_STOP;
                    cyc_d    = CYC_LOAD;
                    bit_d    = STOP_LOAD;
                    serial_d = 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d  = S_STOP;
                    cyc_d    = CYC_LOAD;
                    bit_d    = STOP_LOAD;
                    serial_d = 1'b1;
                end else begin
                    cyc_d = cyc_q - CYC_W'(1);
                end
            end
            S_STOP: begin
                serial_d = 1'b1;
                if (!bit_done) begin
                    cyc_d = cyc_q - CYC_W'(1);
                end else if (bit_q != '0) begin
                    cyc_d = CYC_LOAD;
                    bit_d = bit_q - BIT_W'(1);
                end else if (count_q != '0) begin
                    start_frame = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new frame latches the head word and the parity mode in force right now.
        if (start_frame) begin
            pop      = 1'b1;
            state_d  = S_START;
            cyc_d    = CYC_LOAD;
            serial_d = 1'b0;
            shift_d  = head;
            par_en_d = (i_parity != 2'b00);
            par_d    = parity_bit(head, i_parity);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            serial_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            serial_q <= serial_d;
        end
    end

    // Payload storage carries no reset; control state guards every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_data;
        end
        shift_q  <= shift_d;
        par_en_q <= par_en_d;
        par_q    <= par_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single frames on two configurations,
// plus hand-written sequences for back-to-back streaming and mid-frame reset.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] a_data;
    logic       a_req;
    logic [1:0] a_par;
    logic       a_cts, a_ser, a_idle;
    logic [2:0] a_cnt;

    logic [6:0] b_data;
    logic       b_req;
    logic [1:0] b_par;
    logic       b_cts, b_ser, b_idle;
    logic [2:0] b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .cycles_per_bit(4), .data_bits(8), .stop_bits(1), .fifo_depth(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .i_data(a_data), .i_req(a_req), .i_parity(a_par),
        .o_cts(a_cts), .o_serial(a_ser), .o_idle(a_idle), .o_count(a_cnt)
    );

    uart_tx_fifo #(
        .cycles_per_bit(4), .data_bits(7), .stop_bits(2), .fifo_depth(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .i_data(b_data), .i_req(b_req), .i_parity(b_par),
        .o_cts(b_cts), .o_serial(b_ser), .o_idle(b_idle), .o_count(b_cnt)
    );

    typedef struct {
        bit         sel;    // 0: 8-bit/1-stop unit, 1: 7-bit/2-stop unit
        logic [8:0] data;
        logic [1:0] par;
        int         nbits;  // frame length in bit times
        logic [15:0] line;  // expected line level of each bit time, first bit in [0]
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic frame_level(input logic [7:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        return 1'b1;
    endfunction

    task automatic wait_idle(input bit sel);
        int k = 0;
        while (((sel ? b_idle : a_idle) !== 1'b1) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle", 32'(sel ? b_idle : a_idle), 32'd1);
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        logic s;
        wait_idle(v.sel);
        @(negedge clk);
        if (v.sel) begin b_data = v.data[6:0]; b_par = v.par; b_req = 1'b1; end
        else       begin a_data = v.data[7:0]; a_par = v.par; a_req = 1'b1; end
        @(negedge clk);
        a_req = 1'b0;
        b_req = 1'b0;
        for (int c = 0; c < v.nbits * 4; c++) begin
            @(negedge clk);
            s = v.sel ? b_ser : a_ser;
            check($sformatf("vec%0d bit%0d cyc%0d", idx, c / 4, c % 4), 32'(s), 32'(v.line[c / 4]));
            if (c == 0)
                check($sformatf("vec%0d busy", idx), 32'(v.sel ? b_idle : a_idle), 32'd0);
            // Parity mode must already be latched; flipping it mid-frame must not matter.
            if (c == 8) begin
                a_par = v.par ^ 2'b11;
                b_par = v.par ^ 2'b11;
            end
        end
        @(negedge clk);
        check($sformatf("vec%0d idle_after", idx), 32'(v.sel ? b_idle : a_idle), 32'd1);
        check($sformatf("vec%0d line_after", idx), 32'(v.sel ? b_ser : a_ser), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] w [6];

        vecs[0] = '{1'b0, 9'h055, 2'b00, 10, 16'h02AA};
        vecs[1] = '{1'b0, 9'h007, 2'b01, 11, 16'h060E};
        vecs[2] = '{1'b0, 9'h007, 2'b10, 11, 16'h040E};
        vecs[3] = '{1'b0, 9'h0A3, 2'b11, 11, 16'h0746};
        vecs[4] = '{1'b0, 9'h0FF, 2'b01, 11, 16'h05FE};
        vecs[5] = '{1'b1, 9'h000, 2'b11, 11, 16'h0700};

        rst_n  = 1'b0;
        a_data = '0; a_req = 1'b0; a_par = 2'b00;
        b_data = '0; b_req = 1'b0; b_par = 2'b00;

        // Reset and 100 quiet clocks
        repeat (3) @(negedge clk);
        check("in_reset", 32'({a_ser, a_cts, a_idle, a_cnt}), 32'b111000);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check($sformatf("quiet%0d", i), 32'({a_ser, a_cts, a_idle, a_cnt}), 32'b111000);
        end

        // Single frames from the table
        for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

        // Six pushes on consecutive clocks: five accepted, streamed back-to-back
        w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        wait_idle(1'b0);
        @(negedge clk);
        a_par  = 2'b00;
        a_data = w[0];
        a_req  = 1'b1;
        for (int n = 0; n <= 201; n++) begin
            @(negedge clk);
            if (n < 5) a_data = w[n+1];
            else       a_req = 1'b0;
            if (n == 4 || n == 5) begin
                check($sformatf("full_cnt n%0d", n), 32'(a_cnt), 32'd4);
                check($sformatf("full_cts n%0d", n), 32'(a_cts), 32'd0);
            end
            if (n == 41) begin
                check("drain_cnt", 32'(a_cnt), 32'd3);
                check("drain_cts", 32'(a_cts), 32'd1);
            end
            if (n >= 1 && n <= 200)
                check($sformatf("stream c%0d", n - 1), 32'(a_ser),
                      32'(frame_level(w[(n-1) / 40], ((n-1) % 40) / 4)));
            if (n == 201) begin
                check("stream_idle", 32'(a_idle), 32'd1);
                check("stream_cnt", 32'(a_cnt), 32'd0);
            end
        end

        // Reset during data bit 3 with a second word queued
        wait_idle(1'b0);
        @(negedge clk);
        a_data = 8'h00;
        a_req  = 1'b1;
        @(negedge clk);
        a_data = 8'h0F;
        @(negedge clk);
        a_req = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_rst_line", 32'(a_ser), 32'd0);
        check("pre_rst_cnt", 32'(a_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_line", 32'(a_ser), 32'd1);
        check("rst_cnt", 32'(a_cnt), 32'd0);
        check("rst_idle", 32'(a_idle), 32'd1);
        check("rst_cts", 32'(a_cts), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check($sformatf("post_rst%0d", i), 32'({a_ser, a_idle, a_cnt}), 32'b11000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
